toy_pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RISC_TOY core (IF, ID, EX, MEM, WB).
- Keeps a per-register scoreboard of in-flight writes and interlocks ID on RAW and WAW hazards.
- Runs the branch/jump flush sequence and freezes the whole pipe while data memory is busy.
- Drives stage enables, bubble insertion and flush; also exposes stall and flush performance counters.

---
 rtl/toy_pkg.sv | 36 +++
 rtl/toy_scoreboard.sv | 63 ++++++
 rtl/toy_pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_toy_pipe_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/toy_pkg.sv
// Shared definitions for the RISC_TOY pipeline control slice.
package toy_pkg;

   localparam int TOY_AW   = 5;
   localparam int TOY_NREG = 32;

   localparam logic [4:0] OP_ADDI = 5'b00000;
   localparam logic [4:0] OP_ANDI = 5'b00001;
   localparam logic [4:0] OP_ORI  = 5'b00010;
   localparam logic [4:0] OP_MOVI = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_SUB  = 5'b00101;
   localparam logic [4:0] OP_NEG  = 5'b00110;
   localparam logic [4:0] OP_NOT  = 5'b00111;
   localparam logic [4:0] OP_AND  = 5'b01000;
   localparam logic [4:0] OP_OR   = 5'b01001;
   localparam logic [4:0] OP_XOR  = 5'b01010;
   localparam logic [4:0] OP_LSR  = 5'b01011;
   localparam logic [4:0] OP_ASR  = 5'b01100;
   localparam logic [4:0] OP_SHL  = 5'b01101;
   localparam logic [4:0] OP_ROR  = 5'b01110;
   localparam logic [4:0] OP_BR   = 5'b01111;
   localparam logic [4:0] OP_BRL  = 5'b10000;
   localparam logic [4:0] OP_J    = 5'b10001;
   localparam logic [4:0] OP_JL   = 5'b10010;
   localparam logic [4:0] OP_LD   = 5'b10011;
   localparam logic [4:0] OP_LDR  = 5'b10100;
   localparam logic [4:0] OP_ST   = 5'b10101;
   localparam logic [4:0] OP_STR  = 5'b10110;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/toy_scoreboard.sv
// Per-register count of in-flight writes, with two source read ports,
// a destination read port and an any-busy summary.
module toy_scoreboard
   import toy_pkg::*;
#(
   parameter int NREG = TOY_NREG,
   parameter int AW   = TOY_AW,
   parameter int CW   = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          inc_en_i,
   input  logic [AW-1:0] inc_idx_i,
   input  logic          dec_en_i,
   input  logic [AW-1:0] dec_idx_i,
   input  logic [AW-1:0] ra_idx_i,
   input  logic [AW-1:0] rb_idx_i,
   input  logic [AW-1:0] rd_idx_i,
   output logic [CW-1:0] ra_cnt_o,
   output logic [CW-1:0] rb_cnt_o,
   output logic [CW-1:0] rd_cnt_o,
   output logic          busy_o
);

   logic [CW-1:0] cnt_q [NREG];
   logic [NREG-1:0] inc_hit;
   logic [NREG-1:0] dec_hit;

   // Decode which counters move this cycle and summarise occupancy
   always_comb begin
      inc_hit = '0;
      dec_hit = '0;
      busy_o  = 1'b0;
      for (int unsigned r = 0; r < NREG; r++) begin
         inc_hit[r] = inc_en_i & (inc_idx_i == AW'(r));
         dec_hit[r] = dec_en_i & (dec_idx_i == AW'(r));
         busy_o     = busy_o | (cnt_q[r] != '0);
      end
   end

   // Counter update; simultaneous inc and dec cancel, dec at zero is held
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
      end else begin
         for (int unsigned r = 0; r < NREG; r++) begin
            if (inc_hit[r] && !dec_hit[r]) begin
               cnt_q[r] <= cnt_q[r] + CW'(1);
            end else if (dec_hit[r] && !inc_hit[r] && cnt_q[r] != '0) begin
               cnt_q[r] <= cnt_q[r] - CW'(1);
            end
         end
      end
   end

   assign ra_cnt_o = cnt_q[ra_idx_i];
   assign rb_cnt_o = cnt_q[rb_idx_i];
   assign rd_cnt_o = cnt_q[rd_idx_i];

   dec_at_zero: assert property (@(posedge clk_i) disable iff (rst_i)
      !(dec_en_i && !(inc_en_i && inc_idx_i == dec_idx_i) && cnt_q[dec_idx_i] == '0));

endmodule

// File: rtl/toy_pipe_ctrl.sv
// RISC_TOY pipeline sequencing: RAW/WAW interlock, branch flush, memory freeze
// and saturating stall/flush performance counters.
module toy_pipe_ctrl
   import toy_pkg::*;
#(
   parameter int NREG         = TOY_NREG,
   parameter int AW           = TOY_AW,
   parameter int CW           = 2,
   parameter int FLUSH_CYCLES = 2,
   parameter int WB_BYPASS    = 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          ID_VALID,
   input  logic          ID_USE_A,
   input  logic [AW-1:0] ID_SRC_A,
   input  logic          ID_USE_B,
   input  logic [AW-1:0] ID_SRC_B,
   input  logic          ID_WER,
   input  logic [AW-1:0] ID_DEST,
   input  logic          WB_VALID,
   input  logic          WB_WER,
   input  logic [AW-1:0] WB_DEST,
   input  logic          BR_TAKEN,
   input  logic          DMEM_BUSY,
   output logic          PC_EN,
   output logic          IFID_EN,
   output logic          IDEX_BUBBLE,
   output logic          FLUSH_IFID,
   output logic          ISSUE,
   output logic          FREEZE,
   output logic          SB_BUSY,
   output logic [31:0]   STALL_CNT,
   output logic [31:0]   FLUSH_CNT
);

   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [2:0]    REM_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic          BYPASS   = (WB_BYPASS != 0);

   logic [CW-1:0] cnt_a, cnt_b, cnt_dest;
   logic          sb_busy;
   logic          run, wb_write, wbhit_a, wbhit_b;
   logic          raw, waw, flushing, stall, issue;
   ctrl_state_e   state_q;
   logic [2:0]    rem_q;
   logic [31:0]   stall_cnt_q, stall_cnt_d;
   logic [31:0]   flush_cnt_q, flush_cnt_d;

   toy_scoreboard #(
      .NREG(NREG),
      .AW  (AW),
      .CW  (CW)
   ) u_sb (
      .clk_i    (CLK),
      .rst_i    (RST),
      .inc_en_i (issue & ID_WER),
      .inc_idx_i(ID_DEST),
      .dec_en_i (wb_write & ~DMEM_BUSY),
      .dec_idx_i(WB_DEST),
      .ra_idx_i (ID_SRC_A),
      .rb_idx_i (ID_SRC_B),
      .rd_idx_i (ID_DEST),
      .ra_cnt_o (cnt_a),
      .rb_cnt_o (cnt_b),
      .rd_cnt_o (cnt_dest),
      .busy_o   (sb_busy)
   );

   // Hazard detection and flush/stall arbitration
   always_comb begin
      run      = ~RST & ~DMEM_BUSY;
      wb_write = WB_VALID & WB_WER;
      wbhit_a  = BYPASS & wb_write & (WB_DEST == ID_SRC_A) & (cnt_a == CNT_ONE);
      wbhit_b  = BYPASS & wb_write & (WB_DEST == ID_SRC_B) & (cnt_b == CNT_ONE);
      raw      = ID_VALID & ((ID_USE_A & (cnt_a != '0) & ~wbhit_a) |
                             (ID_USE_B & (cnt_b != '0) & ~wbhit_b));
      waw      = ID_VALID & ID_WER & (cnt_dest == CNT_MAX);
      flushing = BR_TAKEN | (state_q == FLUSH);
      stall    = (raw | waw) & ~flushing;
      issue    = run & ID_VALID & ~stall & ~flushing;
   end

   // Stage enables; reset and freeze override the hazard-driven values
   always_comb begin
      FREEZE      = DMEM_BUSY & ~RST;
      PC_EN       = run & ~stall;
      IFID_EN     = run & ~stall;
      IDEX_BUBBLE = RST | (~DMEM_BUSY & (stall | flushing | ~ID_VALID));
      FLUSH_IFID  = run & flushing;
      ISSUE       = issue;
      SB_BUSY     = sb_busy;
   end

   // Flush sequencer: a taken branch (re)arms the remaining-cycle count
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else if (!DMEM_BUSY) begin
         if (BR_TAKEN) begin
            if (FLUSH_CYCLES > 1) begin
               state_q <= FLUSH;
               rem_q   <= REM_LOAD;
            end else begin
               state_q <= IDLE;
            end
         end else if (state_q == FLUSH) begin
            if (rem_q <= 3'd1) state_q <= IDLE;
            else               rem_q   <= rem_q - 3'd1;
         end
      end
   end

   // Saturating performance counter next-state
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!DMEM_BUSY && stall && stall_cnt_q != '1)    stall_cnt_d = stall_cnt_q + 32'd1;
      if (!DMEM_BUSY && BR_TAKEN && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
   end

   // Performance counter registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign STALL_CNT = stall_cnt_q;
   assign FLUSH_CNT = flush_cnt_q;

endmodule

// File: tb/tb_toy_pipe_ctrl.sv
// Self-checking bench for toy_pipe_ctrl: directed hazard/flush/freeze/reset
// sequences followed by constrained-random traffic against a reference model.
module tb_toy_pipe_ctrl;

   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int CW   = 2;
   localparam int FC   = 2;
   localparam int WBB  = 1;
   localparam int MAXC = (1 << CW) - 1;

   logic          CLK = 1'b0;
   logic          RST, ID_VALID, ID_USE_A, ID_USE_B, ID_WER;
   logic [AW-1:0] ID_SRC_A, ID_SRC_B, ID_DEST, WB_DEST;
   logic          WB_VALID, WB_WER, BR_TAKEN, DMEM_BUSY;
   logic          PC_EN, IFID_EN, IDEX_BUBBLE, FLUSH_IFID, ISSUE, FREEZE, SB_BUSY;
   logic [31:0]   STALL_CNT, FLUSH_CNT;

   toy_pipe_ctrl #(
      .NREG(NREG), .AW(AW), .CW(CW), .FLUSH_CYCLES(FC), .WB_BYPASS(WBB)
   ) dut (
      .CLK(CLK), .RST(RST),
      .ID_VALID(ID_VALID), .ID_USE_A(ID_USE_A), .ID_SRC_A(ID_SRC_A),
      .ID_USE_B(ID_USE_B), .ID_SRC_B(ID_SRC_B), .ID_WER(ID_WER), .ID_DEST(ID_DEST),
      .WB_VALID(WB_VALID), .WB_WER(WB_WER), .WB_DEST(WB_DEST),
      .BR_TAKEN(BR_TAKEN), .DMEM_BUSY(DMEM_BUSY),
      .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IDEX_BUBBLE(IDEX_BUBBLE),
      .FLUSH_IFID(FLUSH_IFID), .ISSUE(ISSUE), .FREEZE(FREEZE), .SB_BUSY(SB_BUSY),
      .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       rst;
      logic       idv;
      logic       ua;
      logic [4:0] sa;
      logic       ub;
      logic [4:0] sb;
      logic       wer;
      logic [4:0] dst;
      logic       wbv;
      logic       wbw;
      logic [4:0] wbd;
      logic       br;
      logic       busy;
   } stim_t;

   // Reference state: outstanding writes per register, flush cycles still owed
   // after the current one, and the two performance counts.
   int          mcnt [NREG];
   int          flush_left;
   logic [31:0] m_scnt, m_fcnt;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic stim_t nop();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t wr(input int d);
      stim_t s;
      s = '0;
      s.idv = 1'b1; s.wer = 1'b1; s.dst = 5'(d);
      return s;
   endfunction

   // Apply one cycle of stimulus, check every output, advance the model.
   task automatic step(input stim_t s);
      bit hit_a, hit_b, raw, waw, flushing, stall, frozen, iss, busy_any;
      RST = s.rst; ID_VALID = s.idv; ID_USE_A = s.ua; ID_SRC_A = s.sa;
      ID_USE_B = s.ub; ID_SRC_B = s.sb; ID_WER = s.wer; ID_DEST = s.dst;
      WB_VALID = s.wbv; WB_WER = s.wbw; WB_DEST = s.wbd;
      BR_TAKEN = s.br; DMEM_BUSY = s.busy;
      #3;
      if (s.rst) begin
         foreach (mcnt[r]) mcnt[r] = 0;
         flush_left = 0; m_scnt = '0; m_fcnt = '0;
         check("rst_pc_en", 32'(PC_EN), 0);
         check("rst_ifid_en", 32'(IFID_EN), 0);
         check("rst_bubble", 32'(IDEX_BUBBLE), 1);
         check("rst_flush", 32'(FLUSH_IFID), 0);
         check("rst_issue", 32'(ISSUE), 0);
         check("rst_freeze", 32'(FREEZE), 0);
         check("rst_sb_busy", 32'(SB_BUSY), 0);
         check("rst_stall_cnt", STALL_CNT, 0);
         check("rst_flush_cnt", FLUSH_CNT, 0);
      end else begin
         busy_any = 0;
         foreach (mcnt[r]) if (mcnt[r] != 0) busy_any = 1;
         hit_a = (WBB != 0) && s.wbv && s.wbw && s.wbd == s.sa && mcnt[s.sa] == 1;
         hit_b = (WBB != 0) && s.wbv && s.wbw && s.wbd == s.sb && mcnt[s.sb] == 1;
         raw = s.idv && ((s.ua && mcnt[s.sa] != 0 && !hit_a) ||
                         (s.ub && mcnt[s.sb] != 0 && !hit_b));
         waw = s.idv && s.wer && mcnt[s.dst] == MAXC;
         flushing = s.br || flush_left > 0;
         stall = (raw || waw) && !flushing;
         frozen = s.busy;
         iss = !frozen && s.idv && !stall && !flushing;
         check("freeze", 32'(FREEZE), 32'(frozen));
         check("pc_en", 32'(PC_EN), 32'(!frozen && !stall));
         check("ifid_en", 32'(IFID_EN), 32'(!frozen && !stall));
         check("bubble", 32'(IDEX_BUBBLE), 32'(!frozen && (stall || flushing || !s.idv)));
         check("flush_ifid", 32'(FLUSH_IFID), 32'(!frozen && flushing));
         check("issue", 32'(ISSUE), 32'(iss));
         check("sb_busy", 32'(SB_BUSY), 32'(busy_any));
         check("stall_cnt", STALL_CNT, m_scnt);
         check("flush_cnt", FLUSH_CNT, m_fcnt);
         if (!frozen) begin
            if (iss && s.wer) mcnt[s.dst]++;
            if (s.wbv && s.wbw) mcnt[s.wbd]--;
            if (stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
            if (s.br && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
            if (s.br) flush_left = FC - 1;
            else if (flush_left > 0) flush_left--;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   stim_t s;
   int    live [$];

   initial begin
      RST = 1'b1; ID_VALID = 0; ID_USE_A = 0; ID_USE_B = 0; ID_WER = 0;
      ID_SRC_A = '0; ID_SRC_B = '0; ID_DEST = '0; WB_VALID = 0; WB_WER = 0;
      WB_DEST = '0; BR_TAKEN = 0; DMEM_BUSY = 0;
      foreach (mcnt[r]) mcnt[r] = 0;
      flush_left = 0; m_scnt = '0; m_fcnt = '0;
      @(posedge CLK); #1;
      s = nop(); s.rst = 1'b1; step(s);

      // RAW on r3: three stall cycles, then issue on the WB cycle via bypass
      step(wr(3));
      s = nop(); s.idv = 1; s.ua = 1; s.sa = 5'd3;
      repeat (3) step(s);
      s.wbv = 1; s.wbw = 1; s.wbd = 5'd3; step(s);
      check("raw_stall_total", STALL_CNT, 32'd3);

      // WAW saturation on r5
      repeat (3) step(wr(5));
      s = wr(5); step(s);
      s.wbv = 1; s.wbw = 1; s.wbd = 5'd5; step(s);
      step(wr(5));
      s = nop(); s.wbv = 1; s.wbw = 1; s.wbd = 5'd5;
      repeat (3) step(s);

      // Branch flush over a pending RAW, then back-to-back branches
      step(wr(1));
      s = nop(); s.idv = 1; s.ua = 1; s.sa = 5'd1; s.br = 1; step(s);
      s.br = 0; step(s);
      s.br = 1; step(s); step(s);
      s.br = 0; step(s);
      s = nop(); s.wbv = 1; s.wbw = 1; s.wbd = 5'd1; step(s);

      // Freeze with a WB and a branch presented
      step(wr(7));
      s = nop(); s.busy = 1; s.wbv = 1; s.wbw = 1; s.wbd = 5'd7; s.br = 1;
      s.idv = 1; s.ua = 1; s.sa = 5'd7;
      repeat (4) step(s);
      s.busy = 0; s.br = 0; s.idv = 0; step(s);
      step(nop());

      // Reset mid-flight
      step(wr(2)); step(wr(2));
      s = nop(); s.br = 1; step(s);
      s = nop(); s.rst = 1; s.br = 1; s.idv = 1; step(s);
      step(nop()); step(nop());

      // Constrained-random traffic
      for (int i = 0; i < 3000; i++) begin
         s = nop();
         s.rst  = ($urandom_range(0, 499) == 0);
         s.idv  = $urandom_range(0, 3) != 0;
         s.ua   = $urandom_range(0, 1);
         s.ub   = $urandom_range(0, 1);
         s.wer  = $urandom_range(0, 2) != 0;
         s.sa   = 5'($urandom_range(0, 7));
         s.sb   = 5'($urandom_range(0, 7));
         s.dst  = 5'($urandom_range(0, 7));
         s.br   = ($urandom_range(0, 11) == 0);
         s.busy = ($urandom_range(0, 7) == 0);
         live.delete();
         foreach (mcnt[r]) if (mcnt[r] > 0) live.push_back(r);
         s.wbv = $urandom_range(0, 1);
         if (live.size() > 0 && $urandom_range(0, 2) != 0) begin
            s.wbw = 1;
            s.wbd = 5'(live[$urandom_range(0, live.size() - 1)]);
         end
         step(s);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
